// File: rtl/prefetch_buffer.sv
// prefetch_buffer: instruction prefetch stage between a variable-latency
// instruction memory and decode. Issues one word-aligned request at a time,
// buffers returned words with their PCs in a DEPTH-entry FIFO and hands them
// to decode over a valid/ready handshake. A redirect flushes the FIFO and
// turns any in-flight request into a stale one whose response is dropped.
//
// Optional feature: define PREFETCH_BYPASS_EN to forward a live response
// straight to decode in the cycle it arrives when the FIFO is empty.

module prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   // IDLE: nothing outstanding; WAIT: live request outstanding;
   // DROP: stale request outstanding, its response will be thrown away.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_req_pc;
   logic [31:0]      r_fifo_pc   [DEPTH];
   logic [31:0]      r_fifo_inst [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_accept;
   logic w_bypass;
   logic w_push;
   logic w_pop;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CNT_W'(DEPTH));

   // A request is only issued with a free slot, so the single response it
   // produces can always be pushed without overflow.
   assign mem_req  = (r_state == ST_IDLE) && !w_full && !rst;
   assign mem_addr = r_fetch_pc;
   assign w_accept = mem_req && mem_ready;

`ifdef PREFETCH_BYPASS_EN
   assign w_bypass = w_empty && (r_state == ST_WAIT) && mem_rvalid && !redirect;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed word taken by decode in the same cycle never enters the FIFO.
   assign w_push = (r_state == ST_WAIT) && mem_rvalid && !redirect
                   && !(w_bypass && inst_ready);
   assign w_pop  = !w_empty && inst_ready && !redirect;

   // Next-state logic: redirect turns an outstanding or just-issued request stale.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)   w_state_nxt = redirect ? ST_DROP : ST_WAIT;
         ST_WAIT: if (mem_rvalid) w_state_nxt = ST_IDLE;
                  else if (redirect) w_state_nxt = ST_DROP;
         ST_DROP: if (mem_rvalid) w_state_nxt = ST_IDLE;
         default:                 w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Fetch address and the PC of the outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
         r_req_pc   <= '0;
      end else begin
         if (w_accept) r_req_pc <= r_fetch_pc;
         if (redirect)      r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   // FIFO pointers and occupancy; redirect flushes in the same edge.
   always_ff @(posedge clk) begin
      if (rst || redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; r_count gates every read, so
      // stale contents are never visible and the array maps onto plain RAM/flops.
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]   <= r_req_pc;
         r_fifo_inst[r_wr_ptr] <= mem_rdata;
      end
   end

   // Decode-side outputs: FIFO head, bypassed response, or zeros when empty.
   always_comb begin
      inst_valid = 1'b0;
      inst       = '0;
      inst_pc    = '0;
      if (!w_empty) begin
         inst_valid = 1'b1;
         inst       = r_fifo_inst[r_rd_ptr];
         inst_pc    = r_fifo_pc[r_rd_ptr];
      end else if (w_bypass) begin
         inst_valid = 1'b1;
         inst       = mem_rdata;
         inst_pc    = r_req_pc;
      end
   end

endmodule

// File: tb/tb_prefetch_buffer.sv
// tb_prefetch_buffer: randomized bench for prefetch_buffer. A transaction-level
// reference (queue of {pc, inst}, next fetch address, and whether the single
// outstanding request is still wanted) predicts the DUT outputs each cycle.
// A random-latency in-order memory answers requests; random redirects, resets,
// decode back-pressure and spurious responses are injected.

module tb_prefetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_1000;
   localparam int          N_CYC    = 6000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   always #5 clk = ~clk;

   prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } entry_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   // Reference model: what decode should see, and what fetch should ask for.
   entry_t      m_q[$];
   logic [31:0] m_fetch;
   logic [31:0] m_req_pc;
   bit          m_busy;     // a request is outstanding
   bit          m_live;     // ...and its data is still wanted

   // Memory model: in-order pending responses.
   rsp_t        mem_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, exp);
      end
   endtask

   initial begin
      bit          exp_req;
      bit          exp_bypass;
      bit          exp_valid;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc;
      bit          accept;
      bit          resp;
      int          phase;

      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      mem_ready   = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rdata   = '0;
      inst_ready  = 1'b0;
      m_fetch     = RESET_PC;
      m_req_pc    = '0;
      m_busy      = 1'b0;
      m_live      = 1'b0;

      for (int c = 0; c < N_CYC; c++) begin
         cyc = c;
         @(negedge clk);

         // ---- drive inputs for this cycle ----
         rst      = (c < 2) || ($urandom_range(0, 249) == 0);
         redirect = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 5) == 0)
            redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else
            redirect_pc = $urandom;
         phase = c % 300;
         if (phase < 40)       inst_ready = 1'b0;
         else if (phase < 150) inst_ready = 1'b1;
         else                  inst_ready = ($urandom_range(0, 2) != 0);

         if (mem_q.size() != 0) begin
            mem_rvalid = (mem_q[0].due == c);
            mem_rdata  = mem_rvalid ? mem_q[0].data : $urandom;
            mem_ready  = 1'b0;
         end else begin
            mem_rvalid = ($urandom_range(0, 19) == 0);  // stray response, must be ignored
            mem_rdata  = $urandom;
            mem_ready  = ($urandom_range(0, 3) != 0);
         end
         #1;

         // ---- expected outputs from the reference ----
         exp_req = !rst && !m_busy && (m_q.size() < DEPTH);
`ifdef PREFETCH_BYPASS_EN
         exp_bypass = (m_q.size() == 0) && m_busy && m_live && mem_rvalid && !redirect;
`else
         exp_bypass = 1'b0;
`endif
         exp_valid = (m_q.size() != 0) || exp_bypass;
         if (m_q.size() != 0) begin
            exp_inst = m_q[0].word;
            exp_pc   = m_q[0].pc;
         end else if (exp_bypass) begin
            exp_inst = mem_rdata;
            exp_pc   = m_req_pc;
         end else begin
            exp_inst = '0;
            exp_pc   = '0;
         end

         check("mem_req", 32'(mem_req), 32'(exp_req));
         if (!rst) check("mem_addr", mem_addr, m_fetch);
         check("inst_valid", 32'(inst_valid), 32'(exp_valid));
         check("inst", inst, exp_inst);
         check("inst_pc", inst_pc, exp_pc);

         // ---- advance memory ----
         if (mem_q.size() != 0 && mem_rvalid) void'(mem_q.pop_front());
         accept = exp_req && mem_ready;
         if (accept) mem_q.push_back('{due: c + $urandom_range(1, 4), data: $urandom});

         // ---- advance reference ----
         resp = m_busy && mem_rvalid;
         if (rst) begin
            m_q.delete();
            m_fetch = RESET_PC;
            m_busy  = 1'b0;
            m_live  = 1'b0;
         end else if (redirect) begin
            m_q.delete();
            m_fetch = {redirect_pc[31:2], 2'b00};
            if (resp) begin
               m_busy = 1'b0;
            end else if (m_busy || accept) begin
               if (accept) m_req_pc = m_fetch;
               m_busy = 1'b1;
               m_live = 1'b0;
            end
         end else begin
            if (!(exp_bypass && inst_ready)) begin
               if ((m_q.size() != 0) && inst_ready) void'(m_q.pop_front());
               if (resp && m_live) m_q.push_back('{pc: m_req_pc, word: mem_rdata});
            end
            if (resp) m_busy = 1'b0;
            if (accept) begin
               m_req_pc = m_fetch;
               m_fetch  = m_fetch + 32'd4;
               m_busy   = 1'b1;
               m_live   = 1'b1;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prefetch_buffer.md
# prefetch_buffer

Instruction prefetch stage between instruction memory and `decode`. Replaces the combinational instruction-memory lookup of `fetch` with a registered request/response interface to a variable-latency instruction memory. Fetched words are buffered with their PCs in a small FIFO and handed to decode over a valid/ready handshake. Branch redirects flush the buffer and discard any in-flight response.

## Interface
- `DEPTH`, default 4: FIFO entries (power of two, ≥2).
- `RESET_PC`, default 32'h0: first fetch address after reset.

- `clk` input 1: clock, all state on posedge.
- `rst` input 1: synchronous reset, active-high.
- `redirect` input 1: branch taken; restart fetch at `redirect_pc`.
- `redirect_pc` input 32: new fetch address (bits [1:0] ignored, treated as 0).
- `mem_req` output 1: fetch request valid.
- `mem_addr` output 32: word-aligned fetch address.
- `mem_ready` input 1: memory accepts request when `mem_req && mem_ready`.
- `mem_rvalid` input 1: response data valid.
- `mem_rdata` input 32: fetched instruction.
- `inst_valid` output 1: `inst`/`inst_pc` valid toward decode.
- `inst` output 32: instruction word.
- `inst_pc` output 32: address of `inst`.
- `inst_ready` input 1: decode consumes when `inst_valid && inst_ready`.

## Operation
- Registers: `fetch_pc`, FIFO of {pc, inst} × DEPTH, `count` (0..DEPTH), 2-bit state.
- States: IDLE (nothing outstanding), WAIT (one live request outstanding), DROP (one stale request outstanding).
- `mem_req` = (state==IDLE) && (count < DEPTH) && !rst; `mem_addr` = `fetch_pc`.
- IDLE: accept → state WAIT, `fetch_pc += 4`, pc of request latched as `req_pc`.
- WAIT + `mem_rvalid`: push {req_pc, mem_rdata}; → IDLE.
- DROP + `mem_rvalid`: discard data; → IDLE.
- At most one outstanding request; count < DEPTH at issue guarantees no overflow.
- Pop on `inst_valid && inst_ready`; push and pop same cycle legal, count unchanged.
- `inst_valid` = count != 0; `inst`/`inst_pc` = FIFO head; 0 when empty.
- `redirect` (highest priority, besides `rst`): `fetch_pc <= {redirect_pc[31:2],2'b00}`, count → 0, pop and push suppressed that cycle. State: WAIT → DROP; IDLE with accept same cycle → DROP; IDLE without accept → IDLE; DROP → DROP; WAIT with `mem_rvalid` same cycle → IDLE (response discarded); DROP with `mem_rvalid` → IDLE.
- `mem_rvalid` in IDLE is a protocol violation; ignored.
- Address arithmetic modulo 2^32; `fetch_pc` wraps 32'hFFFFFFFC → 0.

## Timing
- Reset values: state IDLE, `fetch_pc`=RESET_PC, count 0, `mem_req` 0 during reset cycle, `inst_valid` 0, `inst` 0, `inst_pc` 0.
- First `mem_req` in the cycle after `rst` deasserts.
- Memory returns `mem_rvalid` ≥1 cycle after acceptance, in order.
- Response → `inst_valid`: 1 cycle (0 with bypass, see Configuration).
- Next request issues the cycle after the response; peak rate one instruction per (memory latency + 1) cycles.
- Redirect → first request at new PC: next cycle if no request outstanding, else cycle after the stale response.
- `rst` mid-operation: all state cleared; an outstanding response arriving after reset is ignored (state IDLE).

## Configuration
- `PREFETCH_BYPASS_EN` defined: when count==0, state WAIT, `mem_rvalid`, no `redirect`, the response drives `inst_valid`=1, `inst`=`mem_rdata`, `inst_pc`=`req_pc` combinationally; if `inst_ready` same cycle it is not pushed, else pushed.
- Undefined: all responses go through the FIFO; `inst_valid` never depends combinationally on `mem_rvalid`.

## Test plan
- Reset, RESET_PC=0, memory 1-cycle latency, `inst_ready`=1: requests to 0,4,8,…; decode sees pcs 0,4,8 with `mem_rdata` values, each one cycle after `mem_rvalid`.
- `inst_ready`=0 for 20 cycles, DEPTH=4: exactly 4 requests issued, `mem_req` low thereafter, count=4; release ready → pcs 0,4,8,12 in order, fetching resumes at 16.
- Redirect to 32'h100 while WAIT: queue flushed same cycle, late response discarded, next request addr 0x100, next `inst_pc` 0x100.
- Redirect to 32'h200 in same cycle as accept of addr 0x8: state DROP, response for 0x8 never reaches decode; next request 0x200.
- With `PREFETCH_BYPASS_EN`, empty queue, response for pc 0x4 with `inst_ready`=1: `inst_valid` and `inst_pc`=0x4 in the `mem_rvalid` cycle; count stays 0. Without it: visible one cycle later.
- `rst` asserted while WAIT with 2 queued entries: next cycle `inst_valid`=0, count 0, `mem_addr`=RESET_PC; stale `mem_rvalid` ignored.
